// File: rtl/control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg: shared types and constants for the control_fsm sequencer.
//   - state_t   : sequencer state encoding (also shown on CurrentState/NextState)
//   - OP_*      : instruction opcodes carried in IR[15:12]
//   - ALU_*     : ALU function select codes driven on ALU_s0
// -----------------------------------------------------------------------------
package cu_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/control_fsm_if.sv
// -----------------------------------------------------------------------------
// control_fsm_if: bundle between the control unit and the datapath.
//   IR            : latched instruction from the IR register (datapath -> CU)
//   PC_clr/PC_up  : program counter clear / increment
//   IM_rd, IR_ld  : instruction memory read, IR load enable
//   D_addr, D_wr  : data memory address / write enable
//   RF_*          : register file write/read ports and write-data mux select
//   ALU_s0        : ALU function select
//   Halted        : processor halted flag
//   CurrentState / NextState : debug view of the sequencer
// Modports: master = control unit, slave = datapath side.
// -----------------------------------------------------------------------------
interface control_fsm_if #(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4,
  parameter int ALUS_W  = 3
);

  logic [15:0]        IR;
  logic               PC_clr;
  logic               PC_up;
  logic               IM_rd;
  logic               IR_ld;
  logic [DADDR_W-1:0] D_addr;
  logic               D_wr;
  logic               RF_s;
  logic [RADDR_W-1:0] RF_W_addr;
  logic               RF_W_en;
  logic [RADDR_W-1:0] RF_Ra_addr;
  logic               RF_Ra_rd;
  logic [RADDR_W-1:0] RF_Rb_addr;
  logic               RF_Rb_rd;
  logic [ALUS_W-1:0]  ALU_s0;
  logic               Halted;
  logic [3:0]         CurrentState;
  logic [3:0]         NextState;

  modport master (
    input  IR,
    output PC_clr, PC_up, IM_rd, IR_ld, D_addr, D_wr, RF_s,
           RF_W_addr, RF_W_en, RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd,
           ALU_s0, Halted, CurrentState, NextState
  );

  modport slave (
    output IR,
    input  PC_clr, PC_up, IM_rd, IR_ld, D_addr, D_wr, RF_s,
           RF_W_addr, RF_W_en, RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd,
           ALU_s0, Halted, CurrentState, NextState
  );

endinterface

// File: rtl/control_fsm_inst_decode.sv
// -----------------------------------------------------------------------------
// inst_decode: purely combinational split of the latched instruction.
//   ir        : 16-bit instruction word
//   opcode    : IR[15:12]
//   st_src    : STORE source register      IR[11:8]
//   st_addr   : STORE data address         IR[7:0]
//   ld_addr   : LOAD data address          IR[11:4]
//   ld_dest   : LOAD destination register  IR[3:0]
//   ra/rb/rd  : ADD/SUB operand A, operand B, destination
// -----------------------------------------------------------------------------
module inst_decode (
  input  logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  st_src,
  output logic [7:0]  st_addr,
  output logic [7:0]  ld_addr,
  output logic [3:0]  ld_dest,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rd
);

  assign opcode  = ir[15:12];
  assign st_src  = ir[11:8];
  assign st_addr = ir[7:0];
  assign ld_addr = ir[11:4];
  assign ld_dest = ir[3:0];
  assign ra      = ir[11:8];
  assign rb      = ir[7:4];
  assign rd      = ir[3:0];

endmodule

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm: fetch/decode/execute sequencer for the 16-bit processor.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-high reset, forces INIT
//   bus   : control_fsm_if master modport (IR in, all control strobes out)
// Control outputs are registered: at each edge the value for the state being
// entered is computed from next_state and the IR fields, so they are glitch
// free and equal to a Moore decode of the current state. IR only changes at
// the edge leaving FETCH, and DECODE drives nothing, so every execute state
// sees the same IR that was used to compute its registered outputs.
// -----------------------------------------------------------------------------
module control_fsm
  import cu_pkg::*;
#(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4,
  parameter int ALUS_W  = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  control_fsm_if.master  bus
);

  logic [3:0] opcode;
  logic [3:0] st_src;
  logic [7:0] st_addr;
  logic [7:0] ld_addr;
  logic [3:0] ld_dest;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rd;

  inst_decode u_dec (
    .ir      (bus.IR),
    .opcode  (opcode),
    .st_src  (st_src),
    .st_addr (st_addr),
    .ld_addr (ld_addr),
    .ld_dest (ld_dest),
    .ra      (ra),
    .rb      (rb),
    .rd      (rd)
  );

  state_t             state_reg, state_next;
  logic               pc_clr_reg, pc_clr_next;
  logic               pc_up_reg, pc_up_next;
  logic               im_rd_reg, im_rd_next;
  logic               ir_ld_reg, ir_ld_next;
  logic [DADDR_W-1:0] d_addr_reg, d_addr_next;
  logic               d_wr_reg, d_wr_next;
  logic               rf_s_reg, rf_s_next;
  logic [RADDR_W-1:0] w_addr_reg, w_addr_next;
  logic               w_en_reg, w_en_next;
  logic [RADDR_W-1:0] ra_addr_reg, ra_addr_next;
  logic               ra_rd_reg, ra_rd_next;
  logic [RADDR_W-1:0] rb_addr_reg, rb_addr_next;
  logic               rb_rd_reg, rb_rd_next;
  logic [ALUS_W-1:0]  alu_reg, alu_next;
  logic               halted_reg, halted_next;

  // Next-state logic; unknown encodings fall back to INIT.
  always_comb begin
    state_next = ST_INIT;
    case (state_reg)
      ST_INIT:   state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_STORE: state_next = ST_STORE;
          OP_LOAD:  state_next = ST_LOAD_A;
          OP_ADD:   state_next = ST_ADD;
          OP_SUB:   state_next = ST_SUB;
          OP_HALT:  state_next = ST_HALT;
          default:  state_next = ST_NOOP;
        endcase
      end
      ST_NOOP:   state_next = ST_FETCH;
      ST_LOAD_A: state_next = ST_LOAD_B;
      ST_LOAD_B: state_next = ST_FETCH;
      ST_STORE:  state_next = ST_FETCH;
      ST_ADD:    state_next = ST_FETCH;
      ST_SUB:    state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_INIT;
    endcase
  end

  // Output values for the state about to be entered.
  always_comb begin
    pc_clr_next  = 1'b0;
    pc_up_next   = 1'b0;
    im_rd_next   = 1'b0;
    ir_ld_next   = 1'b0;
    d_addr_next  = '0;
    d_wr_next    = 1'b0;
    rf_s_next    = 1'b0;
    w_addr_next  = '0;
    w_en_next    = 1'b0;
    ra_addr_next = '0;
    ra_rd_next   = 1'b0;
    rb_addr_next = '0;
    rb_rd_next   = 1'b0;
    alu_next     = ALUS_W'(ALU_PASS);
    halted_next  = 1'b0;
    case (state_next)
      ST_INIT:  pc_clr_next = 1'b1;
      ST_FETCH: begin
        im_rd_next = 1'b1;
        pc_up_next = 1'b1;
        ir_ld_next = 1'b1;
      end
      ST_LOAD_A: d_addr_next = DADDR_W'(ld_addr);
      ST_LOAD_B: begin
        d_addr_next = DADDR_W'(ld_addr);
        rf_s_next   = 1'b1;
        w_addr_next = RADDR_W'(ld_dest);
        w_en_next   = 1'b1;
      end
      ST_STORE: begin
        ra_addr_next = RADDR_W'(st_src);
        ra_rd_next   = 1'b1;
        d_addr_next  = DADDR_W'(st_addr);
        d_wr_next    = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        ra_addr_next = RADDR_W'(ra);
        ra_rd_next   = 1'b1;
        rb_addr_next = RADDR_W'(rb);
        rb_rd_next   = 1'b1;
        alu_next     = (state_next == ST_ADD) ? ALUS_W'(ALU_ADD) : ALUS_W'(ALU_SUB);
        w_addr_next  = RADDR_W'(rd);
        w_en_next    = 1'b1;
      end
      ST_HALT: halted_next = 1'b1;
      default: ;
    endcase
  end

  // Asynchronous reset lands directly in INIT with only PC_clr active, so any
  // in-flight write strobe drops without waiting for a clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= ST_INIT;
      pc_clr_reg  <= 1'b1;
      pc_up_reg   <= 1'b0;
      im_rd_reg   <= 1'b0;
      ir_ld_reg   <= 1'b0;
      d_addr_reg  <= '0;
      d_wr_reg    <= 1'b0;
      rf_s_reg    <= 1'b0;
      w_addr_reg  <= '0;
      w_en_reg    <= 1'b0;
      ra_addr_reg <= '0;
      ra_rd_reg   <= 1'b0;
      rb_addr_reg <= '0;
      rb_rd_reg   <= 1'b0;
      alu_reg     <= '0;
      halted_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_clr_reg  <= pc_clr_next;
      pc_up_reg   <= pc_up_next;
      im_rd_reg   <= im_rd_next;
      ir_ld_reg   <= ir_ld_next;
      d_addr_reg  <= d_addr_next;
      d_wr_reg    <= d_wr_next;
      rf_s_reg    <= rf_s_next;
      w_addr_reg  <= w_addr_next;
      w_en_reg    <= w_en_next;
      ra_addr_reg <= ra_addr_next;
      ra_rd_reg   <= ra_rd_next;
      rb_addr_reg <= rb_addr_next;
      rb_rd_reg   <= rb_rd_next;
      alu_reg     <= alu_next;
      halted_reg  <= halted_next;
    end
  end

  assign bus.PC_clr       = pc_clr_reg;
  assign bus.PC_up        = pc_up_reg;
  assign bus.IM_rd        = im_rd_reg;
  assign bus.IR_ld        = ir_ld_reg;
  assign bus.D_addr       = d_addr_reg;
  assign bus.D_wr         = d_wr_reg;
  assign bus.RF_s         = rf_s_reg;
  assign bus.RF_W_addr    = w_addr_reg;
  assign bus.RF_W_en      = w_en_reg;
  assign bus.RF_Ra_addr   = ra_addr_reg;
  assign bus.RF_Ra_rd     = ra_rd_reg;
  assign bus.RF_Rb_addr   = rb_addr_reg;
  assign bus.RF_Rb_rd     = rb_rd_reg;
  assign bus.ALU_s0       = alu_reg;
  assign bus.Halted       = halted_reg;
  assign bus.CurrentState = state_reg;
  assign bus.NextState    = state_next;

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm: scoreboard bench for control_fsm. For every instruction the
// expected per-cycle output vectors are pushed to a queue, then popped and
// compared at each falling edge while the DUT steps through the instruction.
// -----------------------------------------------------------------------------
module tb_control_fsm;
  import cu_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  control_fsm_if bus ();

  control_fsm dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [40:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [40:0] observed();
    return {bus.PC_clr, bus.PC_up, bus.IM_rd, bus.IR_ld, bus.D_addr, bus.D_wr,
            bus.RF_s, bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Ra_rd,
            bus.RF_Rb_addr, bus.RF_Rb_rd, bus.ALU_s0, bus.Halted,
            bus.CurrentState, bus.NextState};
  endfunction

  // Expected outputs in state s for instruction ir, with next state nxt.
  function automatic logic [40:0] exp_vec(input state_t s, input logic [15:0] ir, input state_t nxt);
    logic       pc_clr = 0, pc_up = 0, im_rd = 0, ir_ld = 0, d_wr = 0, rf_s = 0;
    logic       w_en = 0, ra_rd = 0, rb_rd = 0, hlt = 0;
    logic [7:0] d_addr = 0;
    logic [3:0] w_a = 0, ra_a = 0, rb_a = 0;
    logic [2:0] alu = 0;
    case (s)
      ST_INIT:   pc_clr = 1;
      ST_FETCH:  begin im_rd = 1; pc_up = 1; ir_ld = 1; end
      ST_LOAD_A: d_addr = ir[11:4];
      ST_LOAD_B: begin d_addr = ir[11:4]; rf_s = 1; w_a = ir[3:0]; w_en = 1; end
      ST_STORE:  begin ra_a = ir[11:8]; ra_rd = 1; d_addr = ir[7:0]; d_wr = 1; end
      ST_ADD, ST_SUB: begin
        ra_a = ir[11:8]; ra_rd = 1; rb_a = ir[7:4]; rb_rd = 1;
        w_a = ir[3:0]; w_en = 1; alu = (s == ST_ADD) ? 3'd1 : 3'd2;
      end
      ST_HALT:   hlt = 1;
      default: ;
    endcase
    return {pc_clr, pc_up, im_rd, ir_ld, d_addr, d_wr, rf_s, w_a, w_en,
            ra_a, ra_rd, rb_a, rb_rd, alu, hlt, 4'(s), 4'(nxt)};
  endfunction

  // Run one instruction starting at its FETCH cycle; IR is presented during
  // FETCH, the way the IR register would capture it at the end of FETCH.
  task automatic run_inst(input logic [15:0] ir, input int halt_cycles);
    state_t seq[$];
    exp_t   e;
    seq.push_back(ST_FETCH);
    seq.push_back(ST_DECODE);
    case (ir[15:12])
      4'h1: seq.push_back(ST_STORE);
      4'h2: begin seq.push_back(ST_LOAD_A); seq.push_back(ST_LOAD_B); end
      4'h3: seq.push_back(ST_ADD);
      4'h4: seq.push_back(ST_SUB);
      4'h5: for (int k = 0; k < halt_cycles; k++) seq.push_back(ST_HALT);
      default: seq.push_back(ST_NOOP);
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      state_t nxt;
      if (k + 1 < seq.size()) nxt = seq[k+1];
      else if (seq[k] == ST_HALT) nxt = ST_HALT;
      else nxt = ST_FETCH;
      e.tag = $sformatf("ir%h_c%0d", ir, k);
      e.vec = exp_vec(seq[k], ir, nxt);
      sb_q.push_back(e);
    end
    for (int k = 0; k < seq.size(); k++) begin
      @(negedge Clk);
      e = sb_q.pop_front();
      check_val(e.tag, 64'(observed()), 64'(e.vec));
      if (k == 0) bus.IR = ir;
    end
    $display("inst %h: %0d cycles checked", ir, seq.size());
  endtask

  // Reset-state comparison, NextState field excluded.
  task automatic check_reset(input string tag);
    logic [40:0] want;
    want = exp_vec(ST_INIT, bus.IR, ST_INIT);
    check_val(tag, 64'(observed() >> 4), 64'(want >> 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset  = 1'b1;
    bus.IR = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_reset($sformatf("reset_c%0d", k));
    end
    Reset = 1'b0;

    run_inst(16'h21B3, 0);   // LOAD
    run_inst(16'h1A42, 0);   // STORE
    run_inst(16'h3125, 0);   // ADD
    run_inst(16'h4125, 0);   // SUB
    run_inst(16'hF123, 0);   // undefined -> NOOP
    run_inst(16'h0000, 0);   // NOOP
    run_inst(16'h5000, 10);  // HALT held

    // Reset pulse out of HALT.
    #1 Reset = 1'b1;
    #1 check_reset("halt_reset_async");
    @(negedge Clk);
    check_reset("halt_reset_held");
    Reset = 1'b0;

    // ADD interrupted by reset between clock edges.
    run_inst(16'h3125, 0);
    #1 Reset = 1'b1;
    #1 check_val("mid_add_wen", 64'(bus.RF_W_en), 64'd0);
    check_reset("mid_add_state");
    @(negedge Clk);
    Reset = 1'b0;

    run_inst(16'h4125, 0);
    run_inst(16'h1A42, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
